i2c_bus_arbiter: RTL and testbench

//  Shares the single i2c_master between N_REQ transaction sources, e.g. the OLED init sequencer
//   and the hr/min/sec display updater.

---
 rtl/i2c_bus_arbiter_pkg.sv | 28 ++
 rtl/i2c_bus_arbiter_rr_picker.sv | 45 ++++
 rtl/i2c_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter_pkg
//   Shared definitions for the I2C bus arbiter: arbiter FSM states and the
//   transfer descriptor that is forwarded to the single i2c_master.
//   No ports (package).
// -----------------------------------------------------------------------------
package i2c_bus_arbiter_pkg;

   localparam int ADDR_W = 7;   // 7-bit slave address
   localparam int CTRL_W = 8;   // control byte (Co/D#C)
   localparam int DATA_W = 8;   // data byte

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } arb_state_e;

   // One transfer as seen by the master.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              rw;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } desc_t;

endpackage

// File: rtl/i2c_bus_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter_rr_picker
//   Combinational round-robin select: returns the first requester with its
//   request bit set, scanning upward from ptr_i and wrapping at N_REQ.
// Ports:
//   req_i    [N_REQ]  request levels
//   ptr_i    [PW]     requester index with highest priority this round
//   any_o             at least one request present
//   grant_o  [N_REQ]  one-hot winner (zero when any_o = 0)
//   idx_o    [PW]     binary index of the winner
// -----------------------------------------------------------------------------
module i2c_bus_arbiter_rr_picker #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   output logic                     any_o,
   output logic [N_REQ-1:0]         grant_o,
   output logic [$clog2(N_REQ)-1:0] idx_o
);

   localparam int            PW    = $clog2(N_REQ);
   localparam logic [PW:0]   N_EXT = (PW+1)'(N_REQ);

   always_comb begin
      logic [PW:0] cand;
      // NOTE: every output gets a default before the loop, so no path through
      // this block leaves a variable unassigned and no latch is inferred.
      any_o   = 1'b0;
      idx_o   = '0;
      grant_o = '0;
      cand    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         // One extra bit so ptr + i cannot overflow before the wrap.
         cand = {1'b0, ptr_i} + (PW+1)'(i);
         if (cand >= N_EXT) cand = cand - N_EXT;
         if (!any_o && req_i[cand[PW-1:0]]) begin
            any_o = 1'b1;
            idx_o = cand[PW-1:0];
         end
      end
      grant_o = N_REQ'(any_o) << idx_o;
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter
//   Shares one i2c_master between N_REQ transaction sources with round-robin
//   arbitration, locked bursts, per-requester done/err and a watchdog.
// Parameters:
//   N_REQ        number of requesters (2..8)
//   TIMEOUT_CYC  cycles allowed in WAIT before abort; 0 disables the watchdog
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_i / lock_i  [N_REQ]   request level / keep grant after transfer
//   req_addr_i      [7N]      slave address, requester i at [7i+6:7i]
//   req_rw_i        [N]       read/write bit
//   req_ctrl_i      [8N]      control byte
//   req_data_i      [8N]      data byte
//   grant_o         [N]       one-hot registered grant, zero when idle
//   done_o          [N]       1-cycle completion pulse to the granted requester
//   err_o                     valid with done_o: NACK or timeout
//   m_start_o / m_abort_o     1-cycle start / abort pulses to the master
//   m_addr_o, m_rw_o, m_ctrl_o, m_data_o   descriptor, held from start to done
//   m_busy_i, m_done_i, m_nack_i           master status
// -----------------------------------------------------------------------------
module i2c_bus_arbiter
   import i2c_bus_arbiter_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [N_REQ-1:0]         lock_i,
   input  logic [ADDR_W*N_REQ-1:0]  req_addr_i,
   input  logic [N_REQ-1:0]         req_rw_i,
   input  logic [CTRL_W*N_REQ-1:0]  req_ctrl_i,
   input  logic [DATA_W*N_REQ-1:0]  req_data_i,
   output logic [N_REQ-1:0]         grant_o,
   output logic [N_REQ-1:0]         done_o,
   output logic                     err_o,
   output logic                     m_start_o,
   output logic                     m_abort_o,
   output logic [ADDR_W-1:0]        m_addr_o,
   output logic                     m_rw_o,
   output logic [CTRL_W-1:0]        m_ctrl_o,
   output logic [DATA_W-1:0]        m_data_o,
   input  logic                     m_busy_i,
   input  logic                     m_done_i,
   input  logic                     m_nack_i
);

   localparam int              PW       = $clog2(N_REQ);
   localparam logic [PW-1:0]   LAST_IDX = PW'(N_REQ-1);
   localparam bit              WD_EN    = (TIMEOUT_CYC > 0);
   localparam int              TW       = WD_EN ? $clog2(TIMEOUT_CYC+1) : 1;
   localparam logic [TW-1:0]   TO_LAST  = WD_EN ? TW'(TIMEOUT_CYC-1) : '0;

   arb_state_e         state_q;
   logic [N_REQ-1:0]   grant_q;
   logic [PW-1:0]      gidx_q;
   logic [PW-1:0]      rr_ptr_q;
   logic [TW-1:0]      timer_q;
   logic [N_REQ-1:0]   done_q;
   logic               err_q;
   logic               m_start_q;
   logic               m_abort_q;
   desc_t              desc_q;

   logic               pick_any_d;
   logic [N_REQ-1:0]   pick_grant_d;
   logic [PW-1:0]      pick_idx_d;
   desc_t              req_desc   [N_REQ];
   desc_t              sel_desc_d;

   // Completion is taken from m_done alone; the busy level carries no extra
   // information for the arbiter.
   logic unused_m_busy;
   assign unused_m_busy = m_busy_i;

   i2c_bus_arbiter_rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req_i   (req_i),
      .ptr_i   (rr_ptr_q),
      .any_o   (pick_any_d),
      .grant_o (pick_grant_d),
      .idx_o   (pick_idx_d)
   );

   // Unpack the flat requester buses into one descriptor per requester.
   for (genvar i = 0; i < N_REQ; i++) begin : g_desc
      assign req_desc[i] = '{addr: req_addr_i[i*ADDR_W +: ADDR_W],
                             rw:   req_rw_i[i],
                             ctrl: req_ctrl_i[i*CTRL_W +: CTRL_W],
                             data: req_data_i[i*DATA_W +: DATA_W]};
   end

   assign sel_desc_d = req_desc[gidx_q];

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the values from before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         gidx_q    <= '0;
         rr_ptr_q  <= '0;
         timer_q   <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
         m_start_q <= 1'b0;
         m_abort_q <= 1'b0;
         desc_q    <= '0;
      end else begin
         // Pulse outputs fall back to zero unless a state raises them.
         done_q    <= '0;
         err_q     <= 1'b0;
         m_start_q <= 1'b0;
         m_abort_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pick_any_d) begin
                  grant_q <= pick_grant_d;
                  gidx_q  <= pick_idx_d;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               desc_q    <= sel_desc_d;
               m_start_q <= 1'b1;
               timer_q   <= '0;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               // m_done has priority over a timeout landing in the same cycle.
               if (m_done_i) begin
                  err_q   <= m_nack_i;
                  done_q  <= grant_q;
                  state_q <= S_DONE;
               end else if (WD_EN && timer_q == TO_LAST) begin
                  m_abort_q <= 1'b1;
                  err_q     <= 1'b1;
                  done_q    <= grant_q;
                  state_q   <= S_DONE;
               end else if (timer_q != '1) begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_DONE: begin
               // A locked requester that still wants the bus keeps it.
               if (lock_i[gidx_q] && req_i[gidx_q]) begin
                  state_q <= S_LOAD;
               end else begin
                  grant_q  <= '0;
                  rr_ptr_q <= (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grant_o   = grant_q;
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign m_start_o = m_start_q;
   assign m_abort_o = m_abort_q;
   assign m_addr_o  = desc_q.addr;
   assign m_rw_o    = desc_q.rw;
   assign m_ctrl_o  = desc_q.ctrl;
   assign m_data_o  = desc_q.data;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_bus_arbiter
//   Directed bench for i2c_bus_arbiter with two requesters and a 16-cycle
//   watchdog. Expected descriptors are queued when a request is raised and
//   compared when the arbiter issues m_start.
// -----------------------------------------------------------------------------
module tb_i2c_bus_arbiter;
   import i2c_bus_arbiter_pkg::*;

   typedef struct {
      logic [1:0] grant;
      desc_t      d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, lock;
   logic [13:0] req_addr;
   logic [1:0]  req_rw;
   logic [15:0] req_ctrl, req_data;
   logic [1:0]  grant, done;
   logic        err, m_start, m_abort, m_rw;
   logic [6:0]  m_addr;
   logic [7:0]  m_ctrl, m_data;
   logic        m_busy, m_done, m_nack;

   int   n_checks = 0;
   int   n_fails  = 0;
   exp_t sb[$];

   i2c_bus_arbiter #(.N_REQ(2), .TIMEOUT_CYC(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req),
      .lock_i     (lock),
      .req_addr_i (req_addr),
      .req_rw_i   (req_rw),
      .req_ctrl_i (req_ctrl),
      .req_data_i (req_data),
      .grant_o    (grant),
      .done_o     (done),
      .err_o      (err),
      .m_start_o  (m_start),
      .m_abort_o  (m_abort),
      .m_addr_o   (m_addr),
      .m_rw_o     (m_rw),
      .m_ctrl_o   (m_ctrl),
      .m_data_o   (m_data),
      .m_busy_i   (m_busy),
      .m_done_i   (m_done),
      .m_nack_i   (m_nack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "bench time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic desc_t desc_of(input int i);
      desc_t d;
      d.addr = req_addr[i*7 +: 7];
      d.rw   = req_rw[i];
      d.ctrl = req_ctrl[i*8 +: 8];
      d.data = req_data[i*8 +: 8];
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transfer for the requester in g; gap_exp is the number of
   // cycles from the call to the m_start pulse.
   task automatic xfer(input logic [1:0] g, input logic nack, input int gap_exp);
      exp_t e;
      int   cyc;
      int   idx;
      idx     = g[1] ? 1 : 0;
      e.grant = g;
      e.d     = desc_of(idx);
      sb.push_back(e);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (m_start !== 1'b1 && cyc < 40);
      check("m_start_seen", 32'(m_start), 32'd1);
      check("start_latency", 32'(cyc), 32'(gap_exp));
      e = sb.pop_front();
      check("grant_at_start", 32'(grant), 32'(e.grant));
      check("m_addr", 32'(m_addr), 32'(e.d.addr));
      check("m_rw", 32'(m_rw), 32'(e.d.rw));
      check("m_ctrl", 32'(m_ctrl), 32'(e.d.ctrl));
      check("m_data", 32'(m_data), 32'(e.d.data));
      // Requester is free to change its inputs once the transfer started.
      req_data[idx*8 +: 8] = ~req_data[idx*8 +: 8];
      m_busy = 1'b1;
      tick();
      check("m_start_pulse_width", 32'(m_start), 32'd0);
      m_done = 1'b1;
      m_nack = nack;
      tick();
      m_done = 1'b0;
      m_nack = 1'b0;
      m_busy = 1'b0;
      check("done", 32'(done), 32'(g));
      check("err", 32'(err), 32'(nack));
      check("grant_at_done", 32'(grant), 32'(g));
      check("m_data_held", 32'(m_data), 32'(e.d.data));
   endtask

   task automatic idle_check();
      tick();
      check("idle_done", 32'(done), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
   endtask

   initial begin
      int n;
      rst      = 1'b1;
      req      = 2'b00;
      lock     = 2'b00;
      req_addr = {7'h3D, 7'h3C};
      req_rw   = 2'b10;
      req_ctrl = {8'h40, 8'h00};
      req_data = {8'h5A, 8'hAF};
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_nack   = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_m_start", 32'(m_start), 32'd0);
      check("rst_m_abort", 32'(m_abort), 32'd0);
      check("rst_m_addr", 32'(m_addr), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      rst = 1'b0;

      // 1. Single request: grant at +1, m_start at +2
      req = 2'b01;
      tick();
      check("t1_grant_plus1", 32'(grant), 32'h1);
      check("t1_no_start_yet", 32'(m_start), 32'd0);
      xfer(2'b01, 1'b0, 1);
      req = 2'b00;
      idle_check();

      // 2. Contention, no lock: pointer sits at 1 after requester 0 was served
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         xfer((k % 2 == 0) ? 2'b10 : 2'b01, 1'b0, (k == 0) ? 2 : 3);
      end
      req = 2'b00;
      idle_check();

      // 3. Locked burst of three for requester 0 with requester 1 waiting
      req  = 2'b01;
      lock = 2'b01;
      xfer(2'b01, 1'b0, 2);
      req = 2'b11;
      xfer(2'b01, 1'b0, 2);
      xfer(2'b01, 1'b0, 2);
      lock = 2'b00;
      req  = 2'b10;
      xfer(2'b10, 1'b0, 3);
      req = 2'b00;
      idle_check();

      // 4. NACK: err with done, then pointer moves on to requester 1
      req = 2'b01;
      xfer(2'b01, 1'b1, 2);
      req = 2'b11;
      xfer(2'b10, 1'b0, 3);
      req = 2'b00;
      idle_check();

      // 5. Watchdog: abort exactly 16 cycles after m_start
      req = 2'b01;
      n = 0;
      do begin
         tick();
         n++;
      end while (m_start !== 1'b1 && n < 40);
      check("t5_m_start", 32'(m_start), 32'd1);
      n = 0;
      do begin
         tick();
         n++;
      end while (m_abort !== 1'b1 && n < 40);
      check("t5_abort_seen", 32'(m_abort), 32'd1);
      check("t5_abort_cycles", 32'(n), 32'd16);
      check("t5_done", 32'(done), 32'h1);
      check("t5_err", 32'(err), 32'd1);
      req = 2'b00;
      tick();
      check("t5_abort_width", 32'(m_abort), 32'd0);
      check("t5_done_width", 32'(done), 32'd0);
      // Stray m_done outside WAIT must be ignored
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check("t5_stray_done", 32'(done), 32'd0);
      check("t5_stray_grant", 32'(grant), 32'd0);

      // 6. Reset during WAIT, then fresh arbitration starts from requester 0
      req = 2'b10;
      n = 0;
      do begin
         tick();
         n++;
      end while (m_start !== 1'b1 && n < 40);
      check("t6_m_start", 32'(m_start), 32'd1);
      check("t6_m_addr_before", 32'(m_addr), 32'h3D);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("t6_rst_grant", 32'(grant), 32'd0);
      check("t6_rst_m_addr", 32'(m_addr), 32'd0);
      tick();
      check("t6_rst_done", 32'(done), 32'd0);
      check("t6_rst_err", 32'(err), 32'd0);
      check("t6_rst_m_start", 32'(m_start), 32'd0);
      rst = 1'b0;
      req = 2'b11;
      xfer(2'b01, 1'b0, 2);
      req = 2'b00;
      idle_check();

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
